// File: rtl/instr_queue_issue.sv
// Issue end of the instruction queue: buffers pushed entries in a FIFO and expands
// each entry into per-copy instances, issuing up to ISSUE_WIDTH per registered bundle.
module instr_queue_issue #(
    parameter int LOG_DEPTH   = 4,
    parameter int ISSUE_WIDTH = 3,
    parameter int MAX_COPIES  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [15:0]               push_instr,
    input  logic [3:0]                push_copies,
    input  logic [17:0]               push_addr,
    input  logic [17:0]               push_stride,
    input  logic                      issue_ready,
    output logic [ISSUE_WIDTH-1:0]    issue_valid,
    output logic [16*ISSUE_WIDTH-1:0] issue_instr,
    output logic [18*ISSUE_WIDTH-1:0] issue_addr,
    output logic                      issue_last,
    output logic                      queue_empty
);
    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int CNT_W = LOG_DEPTH + 1;

    function automatic logic [3:0] clamp_copies(input logic [3:0] c);
        if (c > 4'(MAX_COPIES)) return 4'(MAX_COPIES);
        return c;
    endfunction

    function automatic logic [3:0] lane_count(input logic [3:0] r);
        if (r > 4'(ISSUE_WIDTH)) return 4'(ISSUE_WIDTH);
        return r;
    endfunction

    logic [15:0]          mem_instr  [DEPTH];
    logic [3:0]           mem_copies [DEPTH];
    logic [17:0]          mem_addr   [DEPTH];
    logic [17:0]          mem_stride [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_next;

    logic [3:0]  rem_p0;
    logic [17:0] cur_addr_p0;
    logic [15:0] head_instr_p0;
    logic [17:0] head_stride_p0;

    logic [3:0]                copies_c;
    logic                      wr_en, out_free, form, pop, load_head;
    logic [3:0]                take_p0;
    logic [ISSUE_WIDTH-1:0]    lane_valid;
    logic [16*ISSUE_WIDTH-1:0] lane_instr;
    logic [18*ISSUE_WIDTH-1:0] lane_addr;

    assign copies_c  = clamp_copies(push_copies);
    assign wr_en     = push_valid && push_ready && (copies_c != 4'd0);
    assign out_free  = (issue_valid == '0) || issue_ready;
    assign form      = out_free && (rem_p0 != 4'd0);
    assign take_p0   = lane_count(rem_p0);
    assign pop       = form && (rem_p0 == take_p0);
    // rem_p0 == 0 means no head is loaded, since zero-copy pushes are never stored
    assign load_head = (rem_p0 == 4'd0) && (count != '0);

    always_comb begin
        count_next = count;
        case ({wr_en, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Stage: FIFO storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr[wr_ptr]  <= push_instr;
            mem_copies[wr_ptr] <= copies_c;
            mem_addr[wr_ptr]   <= push_addr;
            mem_stride[wr_ptr] <= push_stride;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b0;
            rem_p0     <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            push_ready <= (count_next < CNT_W'(DEPTH));
            if (load_head)
                rem_p0 <= mem_copies[rd_ptr];
            else if (form)
                rem_p0 <= rem_p0 - take_p0;
        end
    end

    // Stage p0: head entry expansion state
    always_ff @(posedge clk) begin
        if (load_head) begin
            cur_addr_p0    <= mem_addr[rd_ptr];
            head_instr_p0  <= mem_instr[rd_ptr];
            head_stride_p0 <= mem_stride[rd_ptr];
        end else if (form) begin
            cur_addr_p0 <= cur_addr_p0 + 18'(take_p0) * head_stride_p0;
        end
    end

    always_comb begin
        lane_valid = '0;
        lane_instr = '0;
        lane_addr  = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            lane_valid[k]         = (4'(k) < take_p0);
            lane_instr[16*k +: 16] = head_instr_p0;
            lane_addr[18*k +: 18]  = cur_addr_p0 + 18'(k) * head_stride_p0;
        end
    end

    // Stage p1: registered issue bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid <= '0;
            issue_instr <= '0;
            issue_addr  <= '0;
            issue_last  <= 1'b0;
        end else if (form) begin
            issue_valid <= lane_valid;
            issue_instr <= lane_instr;
            issue_addr  <= lane_addr;
            issue_last  <= pop;
        end else if (issue_ready) begin
            issue_valid <= '0;
            issue_last  <= 1'b0;
        end
    end

    assign queue_empty = (count == '0) && (rem_p0 == 4'd0) && (issue_valid == '0);

endmodule

// File: tb/tb_instr_queue_issue.sv
// Directed bench for instr_queue_issue: single and multi-bundle entries, back-pressure,
// FIFO full, zero/clamped copy counts, address wrap and reset during expansion.
module tb_instr_queue_issue;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            push_valid;
    logic            push_ready;
    logic [15:0]     push_instr;
    logic [3:0]      push_copies;
    logic [17:0]     push_addr;
    logic [17:0]     push_stride;
    logic            issue_ready;
    logic [IW-1:0]   issue_valid;
    logic [16*IW-1:0] issue_instr;
    logic [18*IW-1:0] issue_addr;
    logic            issue_last;
    logic            queue_empty;

    int n_checks = 0;
    int n_errors = 0;

    instr_queue_issue dut (
        .clk         (clk),
        .reset       (reset),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_instr  (push_instr),
        .push_copies (push_copies),
        .push_addr   (push_addr),
        .push_stride (push_stride),
        .issue_ready (issue_ready),
        .issue_valid (issue_valid),
        .issue_instr (issue_instr),
        .issue_addr  (issue_addr),
        .issue_last  (issue_last),
        .queue_empty (queue_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] instr, input logic [3:0] copies,
                        input logic [17:0] addr, input logic [17:0] stride);
        push_valid  = 1'b1;
        push_instr  = instr;
        push_copies = copies;
        push_addr   = addr;
        push_stride = stride;
        tick();
        push_valid  = 1'b0;
    endtask

    task automatic check_bundle(input string tag, input logic [IW-1:0] mask,
                                input logic [17:0] a0, input logic [17:0] a1,
                                input logic [17:0] a2, input logic last,
                                input logic [15:0] instr);
        logic [17:0] exp_a [IW];
        exp_a[0] = a0;
        exp_a[1] = a1;
        exp_a[2] = a2;
        check({tag, ".valid"}, 64'(issue_valid), 64'(mask));
        check({tag, ".last"}, 64'(issue_last), 64'(last));
        for (int k = 0; k < IW; k++) begin
            if (mask[k]) begin
                check($sformatf("%s.addr%0d", tag, k), 64'(issue_addr[18*k +: 18]), 64'(exp_a[k]));
                check($sformatf("%s.instr%0d", tag, k), 64'(issue_instr[16*k +: 16]), 64'(instr));
            end
        end
    endtask

    task automatic run_single(input string tag);
        issue_ready = 1'b1;
        push(16'h1234, 4'd1, 18'h00100, 18'd4);
        check({tag, ".lat0"}, 64'(issue_valid), 64'd0);
        tick();
        check({tag, ".lat1"}, 64'(issue_valid), 64'd0);
        tick();
        check_bundle({tag, ".b0"}, 3'b001, 18'h00100, 18'h0, 18'h0, 1'b1, 16'h1234);
        tick();
        check({tag, ".after_valid"}, 64'(issue_valid), 64'd0);
        check({tag, ".after_empty"}, 64'(queue_empty), 64'd1);
        check({tag, ".hold_addr"}, 64'(issue_addr[17:0]), 64'h100);
    endtask

    initial begin
        int accepted;
        int lasts;
        int lanes;
        logic pr;

        reset       = 1'b1;
        push_valid  = 1'b0;
        push_instr  = '0;
        push_copies = '0;
        push_addr   = '0;
        push_stride = '0;
        issue_ready = 1'b0;
        tick();
        tick();
        check("rst.valid", 64'(issue_valid), 64'd0);
        check("rst.push_ready", 64'(push_ready), 64'd0);
        check("rst.instr", 64'(issue_instr), 64'd0);
        check("rst.addr", 64'(issue_addr), 64'd0);
        check("rst.last", 64'(issue_last), 64'd0);
        reset = 1'b0;
        tick();
        check("post_rst.push_ready", 64'(push_ready), 64'd1);
        check("post_rst.empty", 64'(queue_empty), 64'd1);

        // Scenario 1: single copy
        run_single("s1");

        // Scenario 2: eight copies -> 3,3,2
        issue_ready = 1'b1;
        push(16'hABCD, 4'd8, 18'h00010, 18'd4);
        tick();
        tick();
        check_bundle("s2.b0", 3'b111, 18'h10, 18'h14, 18'h18, 1'b0, 16'hABCD);
        tick();
        check_bundle("s2.b1", 3'b111, 18'h1C, 18'h20, 18'h24, 1'b0, 16'hABCD);
        tick();
        check_bundle("s2.b2", 3'b011, 18'h28, 18'h2C, 18'h0, 1'b1, 16'hABCD);
        tick();
        check("s2.done_valid", 64'(issue_valid), 64'd0);
        check("s2.done_empty", 64'(queue_empty), 64'd1);

        // Scenario 3: back-pressure holds the bundle
        issue_ready = 1'b0;
        push(16'hBEEF, 4'd8, 18'h00010, 18'd4);
        tick();
        tick();
        check_bundle("s3.b0", 3'b111, 18'h10, 18'h14, 18'h18, 1'b0, 16'hBEEF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bundle($sformatf("s3.hold%0d", i), 3'b111, 18'h10, 18'h14, 18'h18, 1'b0, 16'hBEEF);
        end
        issue_ready = 1'b1;
        tick();
        check_bundle("s3.b1", 3'b111, 18'h1C, 18'h20, 18'h24, 1'b0, 16'hBEEF);
        tick();
        check_bundle("s3.b2", 3'b011, 18'h28, 18'h2C, 18'h0, 1'b1, 16'hBEEF);
        tick();
        check("s3.done_empty", 64'(queue_empty), 64'd1);

        // Scenario 4: fill the FIFO
        issue_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 17; i++) begin
            push_valid  = 1'b1;
            push_instr  = 16'(i);
            push_copies = 4'd8;
            push_addr   = 18'(i * 256);
            push_stride = 18'd1;
            pr = push_ready;
            tick();
            if (pr) accepted++;
            if (i == 15) check("s4.full_ready", 64'(push_ready), 64'd0);
        end
        push_valid = 1'b0;
        check("s4.accepted", 64'(accepted), 64'd16);
        tick();
        check("s4.still_full", 64'(push_ready), 64'd0);
        check_bundle("s4.held", 3'b111, 18'h0, 18'h1, 18'h2, 1'b0, 16'h0);
        issue_ready = 1'b1;
        tick();
        check("s4.r1_ready", 64'(push_ready), 64'd0);
        check_bundle("s4.r1", 3'b111, 18'h3, 18'h4, 18'h5, 1'b0, 16'h0);
        tick();
        check("s4.r2_ready", 64'(push_ready), 64'd1);
        check_bundle("s4.r2", 3'b011, 18'h6, 18'h7, 18'h0, 1'b1, 16'h0);
        lasts = 0;
        lanes = 0;
        for (int c = 0; c < 400; c++) begin
            if (issue_valid != '0) lanes += $countones(issue_valid);
            if (issue_valid != '0 && issue_last) lasts++;
            if (queue_empty) break;
            tick();
        end
        check("s4.drain_empty", 64'(queue_empty), 64'd1);
        check("s4.drain_lasts", 64'(lasts), 64'd16);
        check("s4.drain_lanes", 64'(lanes), 64'd122);

        // Scenario 5: zero copies, address wrap, clamp
        issue_ready = 1'b1;
        push(16'h5555, 4'd0, 18'h00123, 18'd1);
        check("s5.zero_empty", 64'(queue_empty), 64'd1);
        push(16'h6666, 4'd2, 18'h3FFFE, 18'd1);
        check("s5.zero_novalid", 64'(issue_valid), 64'd0);
        tick();
        tick();
        check_bundle("s5.two", 3'b011, 18'h3FFFE, 18'h3FFFF, 18'h0, 1'b1, 16'h6666);
        tick();
        check("s5.two_done", 64'(issue_valid), 64'd0);
        push(16'h7777, 4'd3, 18'h3FFFF, 18'd2);
        tick();
        tick();
        check_bundle("s5.wrap", 3'b111, 18'h3FFFF, 18'h00001, 18'h00003, 1'b1, 16'h7777);
        tick();
        push(16'h8888, 4'd15, 18'h0, 18'd1);
        tick();
        tick();
        check_bundle("s5.clamp0", 3'b111, 18'h0, 18'h1, 18'h2, 1'b0, 16'h8888);
        tick();
        check_bundle("s5.clamp1", 3'b111, 18'h3, 18'h4, 18'h5, 1'b0, 16'h8888);
        tick();
        check_bundle("s5.clamp2", 3'b011, 18'h6, 18'h7, 18'h0, 1'b1, 16'h8888);
        tick();
        check("s5.clamp_empty", 64'(queue_empty), 64'd1);

        // Scenario 6: reset mid-expansion
        issue_ready = 1'b1;
        push(16'hAAAA, 4'd8, 18'h00010, 18'd4);
        push(16'hBBBB, 4'd8, 18'h00200, 18'd4);
        push(16'hCCCC, 4'd8, 18'h00300, 18'd4);
        check_bundle("s6.b0", 3'b111, 18'h10, 18'h14, 18'h18, 1'b0, 16'hAAAA);
        tick();
        check_bundle("s6.b1", 3'b111, 18'h1C, 18'h20, 18'h24, 1'b0, 16'hAAAA);
        reset = 1'b1;
        tick();
        check("s6.rst_valid", 64'(issue_valid), 64'd0);
        check("s6.rst_empty", 64'(queue_empty), 64'd1);
        check("s6.rst_push_ready", 64'(push_ready), 64'd0);
        check("s6.rst_addr", 64'(issue_addr), 64'd0);
        reset = 1'b0;
        tick();
        check("s6.rel_push_ready", 64'(push_ready), 64'd1);
        tick();
        check("s6.rel_valid", 64'(issue_valid), 64'd0);
        check("s6.rel_empty", 64'(queue_empty), 64'd1);
        run_single("s6");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
